// File: rtl/csr_pkg.sv
// Shared constants, encodings and mstatus helpers for the CSR sequencer and its
// read-modify-write ALU.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    OP_CSRRW  = 3'd0,
    OP_CSRRS  = 3'd1,
    OP_CSRRC  = 3'd2,
    OP_ECALL  = 3'd3,
    OP_EBREAK = 3'd4,
    OP_MRET   = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } op_e;

  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_T_EPC,
    ST_T_CAUSE,
    ST_T_STAT,
    ST_T_VEC,
    ST_M_STAT,
    ST_M_EPC
  } state_e;

  // What the accepted instruction turned into once legality was decided.
  typedef enum logic [1:0] {
    KIND_CSR,
    KIND_TRAP,
    KIND_MRET
  } kind_e;

  function automatic logic write_required(input op_e op, input logic [31:0] wdata);
    return (op == OP_CSRRW) ||
           (((op == OP_CSRRS) || (op == OP_CSRRC)) && (wdata != 32'd0));
  endfunction

  function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
    logic [31:0] nv;
    nv = old;
    nv[MSTATUS_MPIE] = old[MSTATUS_MIE];
    nv[MSTATUS_MIE]  = 1'b0;
    nv[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return nv;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
    logic [31:0] nv;
    nv = old;
    nv[MSTATUS_MIE]  = old[MSTATUS_MPIE];
    nv[MSTATUS_MPIE] = 1'b1;
    nv[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return nv;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath for CSRRW/CSRRS/CSRRC: new value
// from the old CSR contents and the source operand, plus whether a write is due.
module csr_rmw_alu
  import csr_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  output logic [31:0] new_val,
  output logic        write_needed
);

  always_comb begin
    new_val      = '0;
    write_needed = write_required(op, wdata);
    case (op)
      OP_CSRRW: new_val = wdata;
      OP_CSRRS: new_val = old | wdata;
      OP_CSRRC: new_val = old & ~wdata;
      default:  new_val = '0;
    endcase
  end

endmodule

// File: rtl/csr_sequencer.sv
// Multi-cycle controller sequencing the CSR file's async read port and negedge
// write port for CSR read-modify-write, M-mode trap entry and MRET.
module csr_sequencer
  import csr_pkg::*;
#(
  parameter int MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata
);

  localparam logic [31:0] VEC_MASK = ~((32'd1 << MTVEC_ALIGN) - 32'd1);

  // Handshake: a request is taken at a posedge where req_valid && req_ready;
  // req_ready stays low from that edge until the sequence returns to IDLE,
  // so at most one instruction is in flight and none are queued.
  state_e      state;
  kind_e       kind_q;
  op_e         op_q;
  logic [11:0] csr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] old_q;

  op_e         req_op_e;
  kind_e       req_kind;
  logic [31:0] req_cause;

  logic [31:0] alu_new;
  logic        alu_write;

  csr_rmw_alu u_alu (
    .op           (op_q),
    .old          (csr_rdata),
    .wdata        (wdata_q),
    .new_val      (alu_new),
    .write_needed (alu_write)
  );

  always_comb begin
    req_op_e  = op_e'(req_op);
    req_kind  = KIND_TRAP;
    req_cause = CAUSE_ILLEGAL;
    case (req_op_e)
      OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
        // Address bits [11:10] == 2'b11 mark read-only CSRs.
        if (!((req_csr[11:10] == 2'b11) && write_required(req_op_e, req_wdata))) begin
          req_kind = KIND_CSR;
        end
      end
      OP_ECALL:  req_cause = CAUSE_ECALL_M;
      OP_EBREAK: req_cause = CAUSE_BREAKPOINT;
      OP_MRET:   req_kind  = KIND_MRET;
      default:   req_cause = CAUSE_ILLEGAL;
    endcase
  end

  // The file's read port is asynchronous, so the vector/return target can only
  // be formed combinationally in the cycle that addresses mtvec or mepc.
  assign redirect_pc = redirect_valid
                     ? ((state == ST_T_VEC) ? (csr_rdata & VEC_MASK) : csr_rdata)
                     : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      kind_q         <= KIND_CSR;
      op_q           <= OP_CSRRW;
      csr_q          <= '0;
      wdata_q        <= '0;
      pc_q           <= '0;
      cause_q        <= '0;
      old_q          <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      redirect_valid <= 1'b0;
      csr_addr       <= '0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
    end else begin
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      redirect_valid <= 1'b0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_RD;
            req_ready <= 1'b0;
            kind_q    <= req_kind;
            op_q      <= req_op_e;
            csr_q     <= req_csr;
            wdata_q   <= req_wdata;
            pc_q      <= req_pc;
            cause_q   <= req_cause;
            csr_addr  <= (req_kind == KIND_CSR) ? req_csr : CSR_MSTATUS;
          end
        end
        ST_RD: begin
          old_q    <= csr_rdata;
          csr_addr <= '0;
          case (kind_q)
            KIND_CSR: begin
              state     <= ST_WR;
              rsp_valid <= 1'b1;
              rsp_rdata <= csr_rdata;
              csr_we    <= alu_write;
              csr_waddr <= alu_write ? csr_q : '0;
              csr_wdata <= alu_write ? alu_new : '0;
            end
            KIND_TRAP: begin
              state     <= ST_T_EPC;
              csr_we    <= 1'b1;
              csr_waddr <= CSR_MEPC;
              csr_wdata <= pc_q & 32'hFFFF_FFFC;
            end
            default: begin
              state     <= ST_M_STAT;
              csr_we    <= 1'b1;
              csr_waddr <= CSR_MSTATUS;
              csr_wdata <= mret_mstatus(csr_rdata);
            end
          endcase
        end
        ST_WR: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        ST_T_EPC: begin
          state     <= ST_T_CAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MCAUSE;
          csr_wdata <= cause_q;
        end
        ST_T_CAUSE: begin
          state     <= ST_T_STAT;
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MSTATUS;
          csr_wdata <= trap_mstatus(old_q);
        end
        ST_T_STAT: begin
          state          <= ST_T_VEC;
          csr_addr       <= CSR_MTVEC;
          redirect_valid <= 1'b1;
        end
        ST_T_VEC: begin
          state     <= ST_IDLE;
          csr_addr  <= '0;
          req_ready <= 1'b1;
        end
        ST_M_STAT: begin
          state          <= ST_M_EPC;
          csr_addr       <= CSR_MEPC;
          redirect_valid <= 1'b1;
        end
        ST_M_EPC: begin
          state     <= ST_IDLE;
          csr_addr  <= '0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          csr_addr  <= '0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_sequencer.sv
// Bench for csr_sequencer: a CSR file model on the bus, directed scenarios and
// randomized instruction streams checked against a per-instruction reference model.
module tb_csr_sequencer;

  localparam int ALIGN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_csr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;

  csr_sequencer #(.MTVEC_ALIGN(ALIGN)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_csr        (req_csr),
    .req_wdata      (req_wdata),
    .req_pc         (req_pc),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_addr       (csr_addr),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata)
  );

  // ---------------- clock / reset / CSR file ----------------
  always #5 clk = ~clk;

  bit [31:0] csr_mem   [4096];
  bit [31:0] model_mem [4096];

  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign csr_rdata = csr_mem[csr_addr];

  always @(negedge clk) begin
    if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
    else if (pl_en) csr_mem[pl_addr] <= pl_data;
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;

  logic [51:0] exp_q[$];
  logic [51:0] act_q[$];

  int          exp_rsp_cyc, exp_rd_cyc, exp_ready_cyc;
  logic [31:0] exp_rsp_data, exp_rd_pc;
  int          obs_rsp_cyc, obs_rd_cyc, obs_ready_cyc, obs_viol;
  logic [31:0] obs_rsp_data, obs_rd_pc;

  logic [11:0] watch [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hC00};

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clk); #1;
    pl_en = 1'b0;
    model_mem[addr] = data;
    @(posedge clk); #1;
  endtask

  // Issue one instruction and record everything seen until req_ready returns.
  // Cycle k is the k-th cycle after the accepting edge (RD is k=1).
  task automatic do_op(input logic [2:0] op, input logic [11:0] csr,
                       input logic [31:0] wdata, input logic [31:0] pc, input bit noise);
    obs_rsp_cyc = 0; obs_rd_cyc = 0; obs_ready_cyc = 0; obs_viol = 0;
    obs_rsp_data = '0; obs_rd_pc = '0;
    act_q.delete();
    req_valid = 1'b1; req_op = op; req_csr = csr; req_wdata = wdata; req_pc = pc;
    @(posedge clk); #1;
    if (noise) begin
      req_op = 3'($urandom_range(0, 7));
      req_csr = 12'($urandom());
      req_wdata = $urandom();
      req_pc = $urandom();
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 1; k <= 12; k++) begin
      if (rsp_valid && redirect_valid) obs_viol++;
      if (req_ready && (rsp_valid || redirect_valid || csr_we)) obs_viol++;
      if (rsp_valid) begin obs_rsp_cyc = k; obs_rsp_data = rsp_rdata; end
      if (redirect_valid) begin obs_rd_cyc = k; obs_rd_pc = redirect_pc; end
      if (csr_we) act_q.push_back({8'(k), csr_waddr, csr_wdata});
      if (req_ready) begin obs_ready_cyc = k; break; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Reference model: what one instruction should do to the CSR file and pipeline.
  task automatic model_op(input logic [2:0] op, input logic [11:0] csr,
                          input logic [31:0] wdata, input logic [31:0] pc);
    bit [31:0] old_v, nv, ms, cause;
    bit wr, ill;
    exp_q.delete();
    exp_rsp_cyc = 0; exp_rsp_data = '0; exp_rd_cyc = 0; exp_rd_pc = '0;
    wr  = (op == 3'd0) || ((op == 3'd1 || op == 3'd2) && wdata != 32'd0);
    ill = (op >= 3'd6) || (op <= 3'd2 && csr[11:10] == 2'b11 && wr);
    if (op <= 3'd2 && !ill) begin
      old_v = model_mem[csr];
      nv = (op == 3'd0) ? wdata : (op == 3'd1) ? (old_v | wdata) : (old_v & ~wdata);
      exp_rsp_cyc = 2; exp_rsp_data = old_v; exp_ready_cyc = 3;
      if (wr) exp_q.push_back({8'd2, csr, nv});
    end else if (op == 3'd5) begin
      ms = model_mem[12'h300];
      nv = (ms & ~32'h1888) | 32'h1880 | ({31'b0, ms[7]} << 3);
      exp_q.push_back({8'd2, 12'h300, nv});
      exp_rd_cyc = 3; exp_rd_pc = model_mem[12'h341]; exp_ready_cyc = 4;
    end else begin
      cause = ill ? 32'd2 : (op == 3'd3) ? 32'd11 : 32'd3;
      ms = model_mem[12'h300];
      nv = (ms & ~32'h1888) | 32'h1800 | ({31'b0, ms[3]} << 7);
      exp_q.push_back({8'd2, 12'h341, pc & 32'hFFFF_FFFC});
      exp_q.push_back({8'd3, 12'h342, cause});
      exp_q.push_back({8'd4, 12'h300, nv});
      exp_rd_cyc = 5;
      exp_rd_pc = model_mem[12'h305] & ~((32'd1 << ALIGN) - 32'd1);
      exp_ready_cyc = 6;
    end
    foreach (exp_q[i]) model_mem[exp_q[i][43:32]] = exp_q[i][31:0];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, redirect_valid, redirect_pc, csr_addr, csr_we, csr_waddr, csr_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 12'h0, 1'b0, 12'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rsp=%b redir=%b addr=%h we=%b, required ready=1 others 0",
               req_ready, rsp_valid, redirect_valid, csr_addr, csr_we);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_csrrw();
    model_op(3'd0, 12'h340, 32'hDEADBEEF, 32'h0);
    do_op(3'd0, 12'h340, 32'hDEADBEEF, 32'h0, 1'b0);
    n_cmp++; if (obs_rsp_cyc !== 2) begin n_fail++; $display("FAIL rw_rsp_cycle: got %0d want 2", obs_rsp_cyc); end
    n_cmp++; if (obs_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rw_rdata: got %h want 0", obs_rsp_data); end
    n_cmp++; if (csr_mem[12'h340] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_file: got %h want deadbeef", csr_mem[12'h340]); end
    n_cmp++; if (obs_ready_cyc !== 3) begin n_fail++; $display("FAIL rw_ready_cycle: got %0d want 3", obs_ready_cyc); end
  endtask

  task automatic test_csrrs();
    preload(12'h340, 32'h0F);
    model_op(3'd1, 12'h340, 32'hF0, 32'h0);
    do_op(3'd1, 12'h340, 32'hF0, 32'h0, 1'b0);
    n_cmp++; if (obs_rsp_data !== 32'h0F) begin n_fail++; $display("FAIL rs_rdata: got %h want 0f", obs_rsp_data); end
    n_cmp++; if (csr_mem[12'h340] !== 32'hFF) begin n_fail++; $display("FAIL rs_file: got %h want ff", csr_mem[12'h340]); end
  endtask

  task automatic test_csrrc_zero();
    model_op(3'd2, 12'h340, 32'h0, 32'h0);
    do_op(3'd2, 12'h340, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL rc0_no_write: got %0d writes want 0", act_q.size()); end
    n_cmp++; if (obs_rsp_data !== 32'hFF) begin n_fail++; $display("FAIL rc0_rdata: got %h want ff", obs_rsp_data); end
    n_cmp++; if (csr_mem[12'h340] !== 32'hFF) begin n_fail++; $display("FAIL rc0_file: got %h want ff", csr_mem[12'h340]); end
  endtask

  task automatic test_ecall();
    preload(12'h300, 32'h8);
    preload(12'h305, 32'h203);
    model_op(3'd3, 12'h0, 32'h0, 32'h100);
    do_op(3'd3, 12'h0, 32'h0, 32'h100, 1'b0);
    n_cmp++; if (csr_mem[12'h341] !== 32'h100) begin n_fail++; $display("FAIL ecall_mepc: got %h want 100", csr_mem[12'h341]); end
    n_cmp++; if (csr_mem[12'h342] !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %0d want 11", csr_mem[12'h342]); end
    n_cmp++; if (csr_mem[12'h300] !== 32'h1880) begin n_fail++; $display("FAIL ecall_mstatus: got %h want 1880", csr_mem[12'h300]); end
    n_cmp++; if (obs_rd_cyc !== 5) begin n_fail++; $display("FAIL ecall_redirect_cycle: got %0d want 5", obs_rd_cyc); end
    n_cmp++; if (obs_rd_pc !== 32'h200) begin n_fail++; $display("FAIL ecall_redirect_pc: got %h want 200", obs_rd_pc); end
    n_cmp++; if (obs_rsp_cyc !== 0) begin n_fail++; $display("FAIL ecall_no_rsp: got rsp in cycle %0d want none", obs_rsp_cyc); end
  endtask

  task automatic test_mret();
    preload(12'h341, 32'h104);
    model_op(3'd5, 12'h0, 32'h0, 32'h0);
    do_op(3'd5, 12'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (csr_mem[12'h300] !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want 1888", csr_mem[12'h300]); end
    n_cmp++; if (obs_rd_cyc !== 3) begin n_fail++; $display("FAIL mret_redirect_cycle: got %0d want 3", obs_rd_cyc); end
    n_cmp++; if (obs_rd_pc !== 32'h104) begin n_fail++; $display("FAIL mret_redirect_pc: got %h want 104", obs_rd_pc); end
    n_cmp++; if (obs_ready_cyc !== 4) begin n_fail++; $display("FAIL mret_ready_cycle: got %0d want 4", obs_ready_cyc); end
  endtask

  task automatic test_illegal_ro();
    int hits;
    model_op(3'd0, 12'hC00, 32'h5, 32'h400);
    do_op(3'd0, 12'hC00, 32'h5, 32'h400, 1'b0);
    hits = 0;
    foreach (act_q[i]) if (act_q[i][43:32] == 12'hC00) hits++;
    n_cmp++; if (csr_mem[12'h342] !== 32'd2) begin n_fail++; $display("FAIL ill_mcause: got %0d want 2", csr_mem[12'h342]); end
    n_cmp++; if (hits !== 0 || csr_mem[12'hC00] !== 32'h0) begin n_fail++; $display("FAIL ill_ro_untouched: writes=%0d value=%h want 0/0", hits, csr_mem[12'hC00]); end
    n_cmp++; if (obs_rd_cyc !== 5 || obs_rd_pc !== 32'h200) begin n_fail++; $display("FAIL ill_redirect: cycle %0d pc %h want 5 / 200", obs_rd_cyc, obs_rd_pc); end
    n_cmp++; if (obs_rsp_cyc !== 0) begin n_fail++; $display("FAIL ill_no_rsp: got rsp in cycle %0d want none", obs_rsp_cyc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] prior_cause, prior_stat;
    prior_cause = model_mem[12'h342];
    prior_stat  = model_mem[12'h300];
    req_valid = 1'b1; req_op = 3'd3; req_csr = '0; req_wdata = '0; req_pc = 32'h2A8;
    @(posedge clk); #1; req_valid = 1'b0;       // RD
    @(posedge clk); #1;                         // T_EPC
    @(posedge clk); #1;                         // T_CAUSE
    rst = 1'b1; #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, redirect_valid, redirect_pc, csr_addr, csr_we, csr_waddr, csr_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 12'h0, 1'b0, 12'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL midrst_outputs: ready=%b we=%b waddr=%h wdata=%h, required ready=1 others 0",
               req_ready, csr_we, csr_waddr, csr_wdata);
    end
    @(negedge clk); #1;
    n_cmp++; if (csr_mem[12'h342] !== prior_cause) begin n_fail++; $display("FAIL midrst_mcause: got %h want %h", csr_mem[12'h342], prior_cause); end
    n_cmp++; if (csr_mem[12'h341] !== 32'h2A8) begin n_fail++; $display("FAIL midrst_mepc: got %h want 2a8", csr_mem[12'h341]); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1 || csr_we !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: ready=%b we=%b want 1/0", req_ready, csr_we); end
    n_cmp++; if (csr_mem[12'h300] !== prior_stat) begin n_fail++; $display("FAIL midrst_mstatus: got %h want %h", csr_mem[12'h300], prior_stat); end
    model_mem[12'h341] = 32'h2A8;
  endtask

  function automatic logic [11:0] pick_csr();
    logic [11:0] addrs [8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hC00, 12'hF11, 12'h7C0};
    return addrs[$urandom_range(0, 7)];
  endfunction

  // Request held valid with junk while busy; only the intended op may be taken.
  task automatic test_back_to_back(input int n);
    logic [2:0] op; logic [11:0] csr; logic [31:0] wd, pc;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7)); csr = pick_csr();
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom(); pc = $urandom();
      model_op(op, csr, wd, pc);
      do_op(op, csr, wd, pc, 1'b1);
      n_cmp++; if (obs_ready_cyc !== exp_ready_cyc) begin n_fail++; $display("FAIL b2b_ready op=%0d: got %0d want %0d", op, obs_ready_cyc, exp_ready_cyc); end
      n_cmp++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_writes op=%0d: got %0d want %0d", op, act_q.size(), exp_q.size()); end
      foreach (watch[j]) begin
        n_cmp++;
        if (csr_mem[watch[j]] !== model_mem[watch[j]]) begin
          n_fail++; $display("FAIL b2b_file %h: got %h want %h", watch[j], csr_mem[watch[j]], model_mem[watch[j]]);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [2:0] op; logic [11:0] csr; logic [31:0] wd, pc;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7)); csr = pick_csr();
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom(); pc = $urandom();
      model_op(op, csr, wd, pc);
      do_op(op, csr, wd, pc, 1'b0);
      n_cmp++; if (obs_ready_cyc !== exp_ready_cyc) begin n_fail++; $display("FAIL rnd_ready op=%0d: got %0d want %0d", op, obs_ready_cyc, exp_ready_cyc); end
      n_cmp++; if (obs_rsp_cyc !== exp_rsp_cyc) begin n_fail++; $display("FAIL rnd_rsp_cycle op=%0d: got %0d want %0d", op, obs_rsp_cyc, exp_rsp_cyc); end
      n_cmp++; if (obs_rsp_data !== exp_rsp_data) begin n_fail++; $display("FAIL rnd_rdata op=%0d csr=%h: got %h want %h", op, csr, obs_rsp_data, exp_rsp_data); end
      n_cmp++; if (obs_rd_cyc !== exp_rd_cyc) begin n_fail++; $display("FAIL rnd_redirect_cycle op=%0d: got %0d want %0d", op, obs_rd_cyc, exp_rd_cyc); end
      n_cmp++; if (obs_rd_pc !== exp_rd_pc) begin n_fail++; $display("FAIL rnd_redirect_pc op=%0d: got %h want %h", op, obs_rd_pc, exp_rd_pc); end
      n_cmp++; if (obs_viol !== 0) begin n_fail++; $display("FAIL rnd_pulse_rules op=%0d: got %0d violations want 0", op, obs_viol); end
      n_cmp++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_write_count op=%0d: got %0d want %0d", op, act_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size() && j < act_q.size(); j++) begin
        n_cmp++;
        if (act_q[j] !== exp_q[j]) begin
          n_fail++; $display("FAIL rnd_write%0d op=%0d: got cyc/addr/data %h want %h", j, op, act_q[j], exp_q[j]);
        end
      end
      foreach (watch[j]) begin
        n_cmp++;
        if (csr_mem[watch[j]] !== model_mem[watch[j]]) begin
          n_fail++; $display("FAIL rnd_file %h: got %h want %h", watch[j], csr_mem[watch[j]], model_mem[watch[j]]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_csrrs();
    test_csrrc_zero();
    test_ecall();
    test_mret();
    test_illegal_ro();
    test_reset_mid();
    test_back_to_back(12);
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_sequencer.md
# csr_sequencer

Multi-cycle controller in front of the single-write-port CSR register file. It accepts one CSR-class instruction at a time from the execute stage: CSRRW/CSRRS/CSRRC, ECALL, EBREAK, MRET, or an illegal access. It then sequences the file's asynchronous read port and its negedge write port to perform read-modify-write updates and M-mode trap entry/return, and issues a pipeline redirect when control flow changes.

## Interface
Parameters:
- MTVEC_ALIGN, 2, number of low redirect-PC bits forced to 0 on trap entry

Ports:
- clk  in  1  core clock; CSR file writes on its falling edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&&ready at posedge
- req_op  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 EBREAK, 5 MRET, 6-7 illegal
- req_csr  in  12  target CSR address
- req_wdata  in  32  rs1 value or zero-extended zimm
- req_pc  in  32  PC of the instruction
- rsp_valid  out  1  one-cycle pulse, CSR op done
- rsp_rdata  out  32  old CSR value, for rd
- redirect_valid  out  1  one-cycle pulse, redirect fetch
- redirect_pc  out  32  target PC
- csr_addr  out  12  CSR file read address
- csr_rdata  in  32  CSR file read data, combinational
- csr_we  out  1  CSR file write enable
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  32  CSR file write data

## Operation
- Accept latches op, csr, wdata, pc. Decode at accept:
  - illegal if op is 6-7;
  - illegal if req_csr[11:10]==2'b11 and a write is required (any CSRRW; CSRRS/CSRRC with wdata!=0).
  - Illegal is treated as a trap with cause 2. ECALL uses cause 11, EBREAK cause 3.
- States: IDLE, RD, WR, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC.
- IDLE: req_ready=1. On accept go to RD.
- RD: csr_addr = latched csr (CSR ops) or 0x300 mstatus (traps, MRET). At posedge, old_q <= csr_rdata. No write in RD, so old_q never sees a same-cycle negedge write.
  - Next state: CSR op -> WR; trap -> T_EPC; MRET -> M_STAT.
- WR: write new = RW: wdata; RS: old|wdata; RC: old&~wdata.
  - csr_we=0 when the op is RS/RC and wdata==0.
  - rsp_valid=1, rsp_rdata=old_q. Next state IDLE.
- T_EPC: write 0x341 mepc <= {pc[31:2],2'b00}.
- T_CAUSE: write 0x342 mcause <= cause.
- T_STAT: write 0x300 <= old_q with MPIE(7) <= old MIE(3), MIE <= 0, MPP(12:11) <= 2'b11.
- T_VEC: csr_addr=0x305. redirect_valid=1, redirect_pc = mtvec with low MTVEC_ALIGN bits cleared. Next state IDLE.
- M_STAT: write 0x300 <= old_q with MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
- M_EPC: csr_addr=0x341. redirect_valid=1, redirect_pc = mepc. Next state IDLE.
- csr_we is 0 in every state other than WR, T_EPC, T_CAUSE, T_STAT, M_STAT. csr_addr is 0 when unused.
- rst at any time: state -> IDLE, all outputs 0 except req_ready=1, latched regs 0. An in-flight sequence is abandoned and no further writes occur.

## Timing
- Accept at edge T. RD occupies cycle T+1.
- CSR op: rsp_valid in cycle T+2. req_ready returns in T+3.
- ECALL/EBREAK/illegal: writes in T+2, T+3, T+4; redirect_valid in T+5.
- MRET: write in T+2; redirect_valid in T+3.
- Writes land at the falling edge of the cycle in which csr_we=1. Data read combinationally in the next cycle sees it.
- req_ready is 0 from the accept edge until IDLE is re-entered. No back-to-back accept.
- rsp_valid and redirect_valid are never both 1. They never assert in IDLE.

## Structure
- Package csr_pkg holds:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342);
  - op encodings;
  - cause codes 2/3/11;
  - mstatus bit positions;
  - state enum.
- Sub-module csr_rmw_alu: combinational, computes (op, old, wdata) -> (new, write_needed).
- Top level: the FSM plus latches, roughly 200 lines.

## Test plan
- CSRRW 0x340 with wdata 0xDEADBEEF, file initially 0:
  - rsp in T+2 with rdata 0;
  - 0x340 reads 0xDEADBEEF afterwards.
- CSRRS 0x340, wdata 0xF0, prior 0x0F:
  - rdata 0x0F, new value 0xFF.
- CSRRC 0x340, wdata 0, prior 0xFF:
  - csr_we never asserted;
  - rdata 0xFF.
- ECALL at pc 0x100 with mstatus 0x8 and mtvec 0x203:
  - mepc 0x100, mcause 11, mstatus 0x1880;
  - redirect_pc 0x200 in T+5.
- MRET with mstatus 0x1880 and mepc 0x104:
  - mstatus becomes 0x1888;
  - redirect_pc 0x104 in T+3.
- CSRRW to 0xC00 (read-only):
  - mcause 2, no write to 0xC00, redirect issued.
- Second case, rst asserted in T_CAUSE of an ECALL:
  - mcause is not written;
  - outputs 0 and req_ready=1 immediately.
